// File: rtl/vx_barrier_unit_pkg.sv
// ---------------------------------------------------------------------------
// vx_barrier_unit_pkg
// Shared types and helpers for the warp barrier unit.
//   barrier_state_e : per-slot barrier state (idle, gathering local warps,
//                     requesting the global barrier network, awaiting its
//                     response).
//   up_clog2()      : index width helper that never returns less than 1.
// ---------------------------------------------------------------------------
package vx_barrier_unit_pkg;

  typedef enum logic [1:0] {
    BAR_IDLE   = 2'd0,
    BAR_GATHER = 2'd1,
    BAR_GREQ   = 2'd2,
    BAR_GRSP   = 2'd3
  } barrier_state_e;

  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_barrier_unit_slot.sv
// ---------------------------------------------------------------------------
// vx_barrier_unit_slot
// One barrier slot: tracks the arrival mask, arrival count, latched size and
// global flag, and walks IDLE -> GATHER -> (GREQ -> GRSP) -> IDLE.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   arrive_i       : accepted (non-noop, legal) arrival targeting this slot
//   wid_i          : arriving warp id
//   is_global_i    : barrier spans cores (latched on first arrival)
//   size_m1_i      : local warp count minus 1 (latched on first arrival)
//   grant_i        : gbar network accepted this slot's request
//   rsp_hit_i      : gbar response carries this slot's id
//   state_o        : current slot state
//   mask_o         : warps currently held in this slot
//   req_pend_o     : slot waits for the gbar request handshake
//   done_local_o   : local barrier completes this cycle
//   done_global_o  : global barrier completes this cycle
//   rel_mask_o     : warps released this cycle (zero when nothing completes)
// ---------------------------------------------------------------------------
module vx_barrier_unit_slot
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NW_WIDTH  = 2,
  parameter int SIZE_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive_i,
  input  logic [NW_WIDTH-1:0]  wid_i,
  input  logic                 is_global_i,
  input  logic [SIZE_W-1:0]    size_m1_i,
  input  logic                 grant_i,
  input  logic                 rsp_hit_i,
  output barrier_state_e       state_o,
  output logic [NUM_WARPS-1:0] mask_o,
  output logic                 req_pend_o,
  output logic                 done_local_o,
  output logic                 done_global_o,
  output logic [NUM_WARPS-1:0] rel_mask_o
);

  barrier_state_e       state_q, state_d;
  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [SIZE_W-1:0]    count_q, count_d;
  logic [SIZE_W-1:0]    size_q, size_d;
  logic                 glob_q, glob_d;
  logic [NUM_WARPS-1:0] wid_bit;
  logic [SIZE_W-1:0]    size_eff;
  logic                 glob_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BAR_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      size_q  <= '0;
      glob_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      size_q  <= size_d;
      glob_q  <= glob_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    count_d       = count_q;
    size_d        = size_q;
    glob_d        = glob_q;
    done_local_o  = 1'b0;
    done_global_o = 1'b0;
    rel_mask_o    = '0;
    wid_bit       = NUM_WARPS'(1) << wid_i;
    // The first arrival defines the barrier; later arrivals' size/scope are ignored.
    size_eff      = (state_q == BAR_IDLE) ? size_m1_i   : size_q;
    glob_eff      = (state_q == BAR_IDLE) ? is_global_i : glob_q;

    case (state_q)
      BAR_IDLE, BAR_GATHER: begin
        if (arrive_i) begin
          // count_q holds the arrivals seen so far, so equality means this
          // arrival is the last local warp.
          if (count_q == size_eff) begin
            if (glob_eff) begin
              mask_d  = mask_q | wid_bit;
              count_d = '0;
              size_d  = size_eff;
              glob_d  = 1'b1;
              state_d = BAR_GREQ;
            end else begin
              done_local_o = 1'b1;
              rel_mask_o   = mask_q | wid_bit;
              mask_d       = '0;
              count_d      = '0;
              size_d       = '0;
              glob_d       = 1'b0;
              state_d      = BAR_IDLE;
            end
          end else begin
            mask_d  = mask_q | wid_bit;
            count_d = count_q + SIZE_W'(1);
            size_d  = size_eff;
            glob_d  = glob_eff;
            state_d = BAR_GATHER;
          end
        end
      end
      BAR_GREQ: begin
        if (grant_i) state_d = BAR_GRSP;
      end
      BAR_GRSP: begin
        if (rsp_hit_i) begin
          done_global_o = 1'b1;
          rel_mask_o    = mask_q;
          mask_d        = '0;
          count_d       = '0;
          size_d        = '0;
          glob_d        = 1'b0;
          state_d       = BAR_IDLE;
        end
      end
      default: state_d = BAR_IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign mask_o     = mask_q;
  assign req_pend_o = (state_q == BAR_GREQ);

endmodule

// File: rtl/vx_barrier_unit.sv
// ---------------------------------------------------------------------------
// vx_barrier_unit
// Warp barrier unit between warp-control execute and the scheduler. Holds
// arriving warps stalled per barrier slot, releases them when a local barrier
// completes, and handshakes with the cluster gbar network for global ones.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   barrier_valid/ready        : request handshake (ready low while the
//                                addressed slot is in GREQ or GRSP)
//   barrier_wid/id/is_global/size_m1/is_noop : request fields
//   stalled_mask               : warps held at any barrier
//   release_valid/release_mask : registered one-cycle release pulse
//   gbar_req_valid/id/ready    : global barrier request to the network
//   gbar_rsp_valid/id          : global barrier completion from the network
// ---------------------------------------------------------------------------
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
#(
  parameter  int NUM_WARPS    = 4,
  parameter  int NUM_BARRIERS = 4,
  parameter  int SIZE_W       = up_clog2(NUM_WARPS),
  localparam int NW_WIDTH     = up_clog2(NUM_WARPS),
  localparam int NB_WIDTH     = up_clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 barrier_valid,
  output logic                 barrier_ready,
  input  logic [NW_WIDTH-1:0]  barrier_wid,
  input  logic [NB_WIDTH-1:0]  barrier_id,
  input  logic                 barrier_is_global,
  input  logic [SIZE_W-1:0]    barrier_size_m1,
  input  logic                 barrier_is_noop,
  output logic [NUM_WARPS-1:0] stalled_mask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 gbar_req_valid,
  output logic [NB_WIDTH-1:0]  gbar_req_id,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]  gbar_rsp_id
);

  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic [NB_WIDTH-1:0] id;
    logic                is_global;
    logic [SIZE_W-1:0]   size_m1;
    logic                is_noop;
  } barrier_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_req_t;

  barrier_t             req;
  gbar_req_t            gbar_req;
  logic                 accept;
  barrier_state_e       slot_state    [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_mask     [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_rel_mask [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] slot_req_pend, slot_done_local, slot_done_global;
  logic                 arb_valid;
  logic [NB_WIDTH-1:0]  arb_id;
  logic                 lock_q, lock_d;
  logic [NB_WIDTH-1:0]  lock_id_q, lock_id_d;
  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;

  assign req = '{wid: barrier_wid, id: barrier_id, is_global: barrier_is_global,
                 size_m1: barrier_size_m1, is_noop: barrier_is_noop};

  assign barrier_ready = !((slot_state[req.id] == BAR_GREQ) ||
                           (slot_state[req.id] == BAR_GRSP));

  // Duplicate arrivals are dropped so a misbehaving warp cannot corrupt a count.
  assign accept = barrier_valid && barrier_ready && !req.is_noop &&
                  !stalled_mask[req.wid];

  for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
    vx_barrier_unit_slot #(
      .NUM_WARPS (NUM_WARPS),
      .NW_WIDTH  (NW_WIDTH),
      .SIZE_W    (SIZE_W)
    ) u_slot (
      .clk           (clk),
      .reset         (reset),
      .arrive_i      (accept && (req.id == NB_WIDTH'(g))),
      .wid_i         (req.wid),
      .is_global_i   (req.is_global),
      .size_m1_i     (req.size_m1),
      .grant_i       (gbar_req_valid && gbar_req_ready && (gbar_req.id == NB_WIDTH'(g))),
      .rsp_hit_i     (gbar_rsp_valid && (gbar_rsp_id == NB_WIDTH'(g))),
      .state_o       (slot_state[g]),
      .mask_o        (slot_mask[g]),
      .req_pend_o    (slot_req_pend[g]),
      .done_local_o  (slot_done_local[g]),
      .done_global_o (slot_done_global[g]),
      .rel_mask_o    (slot_rel_mask[g])
    );
  end

  always_comb begin
    stalled_mask = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) stalled_mask |= slot_mask[i];
  end

  // Fixed priority, lowest slot id wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (slot_req_pend[i]) begin
        arb_valid = 1'b1;
        arb_id    = NB_WIDTH'(i);
      end
    end
  end

  // Once offered, a request id is locked until accepted so a lower slot
  // entering GREQ later cannot change the id under a stalled handshake.
  assign gbar_req_valid = lock_q || arb_valid;
  assign gbar_req.id    = lock_q ? lock_id_q : arb_id;
  assign gbar_req_id    = gbar_req.id;
  assign lock_d         = gbar_req_valid && !gbar_req_ready;
  assign lock_id_d      = gbar_req.id;

  // Local completions and gbar responses landing together merge into one pulse.
  always_comb begin
    rel_valid_d = 1'b0;
    rel_mask_d  = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      rel_valid_d = rel_valid_d | slot_done_local[i] | slot_done_global[i];
      rel_mask_d  = rel_mask_d | slot_rel_mask[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      rel_valid_q <= 1'b0;
      rel_mask_q  <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rel_valid_q <= rel_valid_d;
      rel_mask_q  <= rel_mask_d;
    end
  end

  assign release_valid = rel_valid_q;
  assign release_mask  = rel_mask_q;

  dup_arrival_a: assert property (@(posedge clk) disable iff (reset)
    !(barrier_valid && barrier_ready && !barrier_is_noop && stalled_mask[barrier_wid]));

endmodule

// File: tb/tb_vx_barrier_unit.sv
// ---------------------------------------------------------------------------
// tb_vx_barrier_unit
// Directed scenarios with literal expectations followed by randomized traffic,
// all checked every cycle against a behavioural barrier model.
// ---------------------------------------------------------------------------
module tb_vx_barrier_unit;
  localparam int NB = 4;
  localparam int NW = 4;
  localparam int P_IDLE = 0, P_GATH = 1, P_WREQ = 2, P_WRSP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       barrier_valid = 1'b0;
  logic       barrier_ready;
  logic [1:0] barrier_wid = '0;
  logic [1:0] barrier_id = '0;
  logic       barrier_is_global = 1'b0;
  logic [1:0] barrier_size_m1 = '0;
  logic       barrier_is_noop = 1'b0;
  logic [3:0] stalled_mask;
  logic       release_valid;
  logic [3:0] release_mask;
  logic       gbar_req_valid;
  logic [1:0] gbar_req_id;
  logic       gbar_req_ready = 1'b0;
  logic       gbar_rsp_valid = 1'b0;
  logic [1:0] gbar_rsp_id = '0;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: each barrier is a set of arrived warps plus a phase.
  int         ph  [NB];
  logic [3:0] msk [NB];
  int         sz  [NB];
  bit         gl  [NB];
  bit         hold;
  int         hold_id;
  bit         e_rv;
  logic [3:0] e_rm;

  always #5 clk = ~clk;

  vx_barrier_unit dut (
    .clk               (clk),
    .reset             (reset),
    .barrier_valid     (barrier_valid),
    .barrier_ready     (barrier_ready),
    .barrier_wid       (barrier_wid),
    .barrier_id        (barrier_id),
    .barrier_is_global (barrier_is_global),
    .barrier_size_m1   (barrier_size_m1),
    .barrier_is_noop   (barrier_is_noop),
    .stalled_mask      (stalled_mask),
    .release_valid     (release_valid),
    .release_mask      (release_mask),
    .gbar_req_valid    (gbar_req_valid),
    .gbar_req_id       (gbar_req_id),
    .gbar_req_ready    (gbar_req_ready),
    .gbar_rsp_valid    (gbar_rsp_valid),
    .gbar_rsp_id       (gbar_rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_stalled();
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s |= msk[i];
    return s;
  endfunction

  function automatic bit m_ready(input int id);
    return ph[id] < P_WREQ;
  endfunction

  function automatic bit m_req_valid();
    if (hold) return 1'b1;
    for (int i = 0; i < NB; i++) if (ph[i] == P_WREQ) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_req_id();
    if (hold) return hold_id;
    for (int i = 0; i < NB; i++) if (ph[i] == P_WREQ) return i;
    return 0;
  endfunction

  function automatic void m_free(input int s);
    ph[s] = P_IDLE; msk[s] = '0; sz[s] = 0; gl[s] = 1'b0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NB; i++) m_free(i);
    hold = 1'b0; hold_id = 0; e_rv = 1'b0; e_rm = '0;
  endfunction

  // Advance the model across one clock edge using the inputs held this cycle.
  task automatic model_step();
    logic [3:0] st, wb, nrm;
    bit rdy, rv, nrv;
    int rid, s;
    st  = m_stalled();
    rdy = m_ready(int'(barrier_id));
    rv  = m_req_valid();
    rid = m_req_id();
    nrv = 1'b0;
    nrm = '0;
    if (gbar_rsp_valid && ph[gbar_rsp_id] == P_WRSP) begin
      nrv = 1'b1;
      nrm |= msk[gbar_rsp_id];
      m_free(int'(gbar_rsp_id));
    end
    if (rv && gbar_req_ready) begin
      ph[rid] = P_WRSP;
      hold = 1'b0;
    end else begin
      hold = rv;
      hold_id = rid;
    end
    if (barrier_valid && rdy && !barrier_is_noop && !st[barrier_wid]) begin
      s  = int'(barrier_id);
      wb = 4'b0001 << barrier_wid;
      if (ph[s] == P_IDLE) begin
        sz[s] = int'(barrier_size_m1);
        gl[s] = barrier_is_global;
      end
      if ($countones(msk[s]) == sz[s]) begin
        if (gl[s]) begin
          msk[s] |= wb;
          ph[s] = P_WREQ;
        end else begin
          nrv = 1'b1;
          nrm |= msk[s] | wb;
          m_free(s);
        end
      end else begin
        msk[s] |= wb;
        ph[s] = P_GATH;
      end
    end
    e_rv = nrv;
    e_rm = nrm;
  endtask

  task automatic compare_model();
    chk("ready", barrier_ready, m_ready(int'(barrier_id)));
    chk("stalled", stalled_mask, m_stalled());
    chk("req_valid", gbar_req_valid, m_req_valid());
    if (m_req_valid()) chk("req_id", gbar_req_id, m_req_id());
    chk("rel_valid", release_valid, e_rv);
    if (e_rv) chk("rel_mask", release_mask, e_rm);
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle();
    barrier_valid = 1'b0; barrier_is_noop = 1'b0; barrier_is_global = 1'b0;
    gbar_req_ready = 1'b0; gbar_rsp_valid = 1'b0;
  endtask

  task automatic arrive(input int wid, input int id, input int sm, input bit glob);
    barrier_valid = 1'b1; barrier_is_noop = 1'b0;
    barrier_wid = 2'(wid); barrier_id = 2'(id);
    barrier_size_m1 = 2'(sm); barrier_is_global = glob;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_stalled", stalled_mask, 0);
    chk("rst_rel_valid", release_valid, 0);
    chk("rst_rel_mask", release_mask, 0);
    chk("rst_req_valid", gbar_req_valid, 0);
    m_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] st;
    int free_w[$];
    int wrsp[$];
    bit any_wait;

    idle();
    m_clear();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_stalled", stalled_mask, 0);
    chk("reset_rel_valid", release_valid, 0);
    chk("reset_rel_mask", release_mask, 0);
    chk("reset_req_valid", gbar_req_valid, 0);
    chk("reset_req_id", gbar_req_id, 0);
    chk("reset_ready", barrier_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Local barrier on slot 1 needing four warps.
    arrive(0, 1, 3, 0); cycle();
    arrive(1, 1, 3, 0); cycle();
    arrive(2, 1, 3, 0); cycle();
    idle(); settle();
    chk("t1_stalled", stalled_mask, 4'b0111);
    advance();
    arrive(3, 1, 3, 0); settle(); advance();
    idle(); settle();
    chk("t1_rel_valid", release_valid, 1);
    chk("t1_rel_mask", release_mask, 4'b1111);
    chk("t1_stalled_clr", stalled_mask, 0);
    advance();
    settle();
    chk("t1_one_pulse", release_valid, 0);
    advance();

    // Global barrier on slot 2 with a back-pressured request.
    arrive(0, 2, 1, 1); cycle();
    arrive(1, 2, 1, 1); cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_req_valid", gbar_req_valid, 1);
      chk("t2_req_id", gbar_req_id, 2);
      advance();
    end
    gbar_req_ready = 1'b1; settle();
    chk("t2_stalled", stalled_mask, 4'b0011);
    advance();
    idle(); arrive(3, 2, 0, 0); settle();
    chk("t2_busy_ready", barrier_ready, 0);
    chk("t2_req_dropped", gbar_req_valid, 0);
    advance();
    idle(); gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd2; settle();
    chk("t2_no_early_rel", release_valid, 0);
    advance();
    idle(); settle();
    chk("t2_rel_valid", release_valid, 1);
    chk("t2_rel_mask", release_mask, 4'b0011);
    chk("t2_stalled_clr", stalled_mask, 0);
    advance();

    // No-op request leaves everything alone.
    arrive(0, 0, 1, 0); cycle();
    idle(); barrier_valid = 1'b1; barrier_is_noop = 1'b1; barrier_wid = 2'd2; barrier_id = 2'd0;
    settle();
    chk("t3_noop_ready", barrier_ready, 1);
    advance();
    idle(); settle();
    chk("t3_stalled", stalled_mask, 4'b0001);
    chk("t3_no_rel", release_valid, 0);
    advance();

    // Local completion on slot 0 coincides with gbar response for slot 3.
    arrive(2, 3, 1, 1); cycle();
    arrive(3, 3, 1, 1); cycle();
    idle(); gbar_req_ready = 1'b1; settle();
    chk("t5_req_id", gbar_req_id, 3);
    advance();
    idle(); arrive(1, 0, 1, 0); gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd3; settle();
    chk("t5_stalled", stalled_mask, 4'b1101);
    advance();
    idle(); settle();
    chk("t5_rel_valid", release_valid, 1);
    chk("t5_rel_mask", release_mask, 4'b1111);
    chk("t5_stalled_clr", stalled_mask, 0);
    advance();
    settle();
    chk("t5_one_pulse", release_valid, 0);
    advance();

    // Single-warp local barrier releases immediately.
    idle(); arrive(2, 1, 0, 0); settle(); advance();
    idle(); settle();
    chk("t4_rel_valid", release_valid, 1);
    chk("t4_rel_mask", release_mask, 4'b0100);
    chk("t4_never_stalled", stalled_mask, 0);
    advance();

    // Reset in the middle of a gather; slot restarts with a new size.
    arrive(0, 1, 3, 0); cycle();
    arrive(1, 1, 3, 0); cycle();
    idle(); settle();
    chk("t6_stalled", stalled_mask, 4'b0011);
    async_reset();
    arrive(0, 1, 0, 0); settle(); advance();
    idle(); settle();
    chk("t6_fresh_rel", release_valid, 1);
    chk("t6_fresh_mask", release_mask, 4'b0001);
    advance();

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      st = m_stalled();
      any_wait = 1'b0;
      for (int i = 0; i < NB; i++) if (ph[i] >= P_WREQ) any_wait = 1'b1;
      if ((st == 4'hF && !any_wait) || $urandom_range(0, 299) == 0) begin
        async_reset();
        continue;
      end
      idle();
      free_w.delete();
      for (int w = 0; w < NW; w++) if (!st[w]) free_w.push_back(w);
      wrsp.delete();
      for (int i = 0; i < NB; i++) if (ph[i] == P_WRSP) wrsp.push_back(i);
      barrier_valid     = 1'($urandom_range(0, 1));
      barrier_id        = 2'($urandom_range(0, 3));
      barrier_is_global = ($urandom_range(0, 2) == 0);
      barrier_size_m1   = 2'($urandom_range(0, 3));
      barrier_is_noop   = ($urandom_range(0, 7) == 0) || (free_w.size() == 0);
      if (free_w.size() != 0)
        barrier_wid = 2'(free_w[$urandom_range(0, free_w.size() - 1)]);
      else
        barrier_wid = 2'($urandom_range(0, 3));
      gbar_req_ready = 1'($urandom_range(0, 1));
      gbar_rsp_valid = ($urandom_range(0, 2) == 0);
      if (wrsp.size() != 0 && $urandom_range(0, 3) != 0)
        gbar_rsp_id = 2'(wrsp[$urandom_range(0, wrsp.size() - 1)]);
      else
        gbar_rsp_id = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
